muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer that owns the architectural HI/LO registers for the pipelined MIPS core.
- Executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo. Uses the same 5-bit operation codes as the core ALU.
- Drives a stall to the pipeline while a HI/LO-dependent instruction waits on an operation in flight.
- Sits beside the ALU in EX. Non-HI/LO ops never stall and are ignored.

Parameters:
- MUL_LAT, 4, cycles an accepted multiply spends in MUL state (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  EX stage presents an operation this cycle.
- operation  input  5  op code: 01111 div, 10000 divu, 10001 mult, 10010 multu, 10011 mfhi, 10100 mflo, 10101 mthi, 10111 mtlo.
- a  input  32  operand A (rs): dividend, multiplicand, or mthi/mtlo source.
- b  input  32  operand B (rt): divisor or multiplier.
- flush  input  1  pipeline flush; aborts any operation in flight.
- stall  output  1  combinational; hold EX.
- busy  output  1  registered; unit is in MUL, DIV or FIX.
- done  output  1  registered; one-cycle pulse after a mult/div result is written.
- rd_data  output  32  combinational; HI for mfhi, LO for mflo, else 0.
- hi_out  output  32  current HI register.
- lo_out  output  32  current LO register.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, HI=0, LO=0, busy=0, done=0, counters=0. Reset overrides flush and op_valid.
- Code matching:
  - hilo_op = op_valid and operation is one of the 8 codes above.
  - stall = hilo_op && busy. No other condition stalls.
  - accept = hilo_op && !busy && !flush.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - accept mult/multu: compute the 64-bit product (signed or unsigned) into prod_q; cnt=MUL_LAT-1; go to MUL.
  - accept div/divu with b!=0:
    - Latch magnitudes |a| and |b| (signed op) or raw a and b (divu).
    - Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (signed op only).
    - Clear remainder accumulator; iter=31; go to DIV.
  - accept div/divu with b==0: in one cycle write LO=32'hFFFFFFFF, HI=a; stay in IDLE; done=1 next cycle.
  - accept mthi/mtlo: write HI or LO with a at the edge; no done pulse.
  - mfhi/mflo: rd_data = HI/LO combinationally, same cycle; no state change.
- MUL: each cycle cnt--. At the edge where cnt==0: HI=prod_q[63:32], LO=prod_q[31:0]; go to IDLE; done=1 next cycle.
- DIV:
  - Restoring radix-2, one quotient bit per cycle, MSB first, 32 cycles.
  - Each step: rem={rem[30:0],dvd[iter]}; if rem>=dsr, then rem-=dsr and set the q bit.
  - At iter==0, go to FIX.
- FIX:
  - Negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
  - Write LO=quotient, HI=remainder; go to IDLE; done=1 next cycle.
- Latency, accept at the edge ending cycle T:
  - mult: busy in T+1..T+MUL_LAT; HI/LO valid and done=1 in T+MUL_LAT+1.
  - div: busy in T+1..T+33; HI/LO valid and done=1 in T+34.
- Back-to-back: a new op may be accepted in the cycle done=1; it sees the updated HI/LO.
- Signed overflow: 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Flush, when not in reset:
  - Return to IDLE; HI/LO unchanged; done=0 next cycle.
  - An op presented in the same cycle is discarded.
  - mthi/mtlo presented with flush does not write.
- While busy:
  - mthi/mtlo and new mult/div are stalled, not queued.
  - rd_data still reflects the current (old) HI/LO, but stall is asserted, so the pipeline must not consume it.
- Arithmetic: all widths are 32 bits except the 64-bit product and the 33-bit compare (rem vs dsr). The unit never raises exceptions.

Test Plan:
- Reset, then mthi a=0x12345678, then mfhi: rd_data=0x12345678 in the same cycle as the mfhi; stall=0; lo_out=0.
- mult a=0xFFFFFFFE (-2), b=3 with MUL_LAT=4:
  - busy for 4 cycles, done in cycle T+5.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2:
  - busy for 33 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); done=1 at T+34.
  - divu a=100, b=7 gives LO=14, HI=2.
- div a=5, b=0: LO=0xFFFFFFFF, HI=5, done next cycle, busy never set. Signed 0x80000000 div -1 gives LO=0x80000000, HI=0.
- Start div, present mflo at cycle T+10:
  - stall=1 through T+33 and 0 at T+34.
  - mflo returns the new quotient at T+34.
  - An add op presented at T+10 gives stall=0.
- Start mult with HI=0xAAAA0000, assert flush at T+2:
  - busy=0 at T+3, done never pulses, HI stays 0xAAAA0000.
  - reset asserted mid-DIV gives HI=LO=0 and state IDLE next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the MIPS EX stage: multi-cycle mult/div, mfhi/mflo/mthi/mtlo,
// and the pipeline stall for HI/LO-dependent instructions while an operation is in flight.
module muldiv_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [4:0]  operation,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;
    localparam logic [39:0] HILO_CODES = {OP_DIV, OP_DIVU, OP_MULT, OP_MULTU,
                                          OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_reg, state_next;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg;
    logic [63:0] prod_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] dvd_reg, dsr_reg, rem_reg, quo_reg;
    logic [4:0]  iter_reg;
    logic        q_neg_reg, r_neg_reg;

    logic [7:0]  code_hit;
    logic        hilo_op, accept, div_signed;
    logic [63:0] mul_s, mul_u;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_shift, rem_diff;

    for (genvar gi = 0; gi < 8; gi++) begin : g_code
        assign code_hit[gi] = (operation == HILO_CODES[gi*5 +: 5]);
    end

    assign hilo_op    = op_valid && (|code_hit);
    assign busy       = (state_reg != IDLE);
    assign accept     = hilo_op && !busy && !flush;
    assign done       = done_reg;
    assign hi_out     = hi_reg;
    assign lo_out     = lo_reg;
    assign div_signed = (operation == OP_DIV);

    assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign mul_u = {32'd0, a} * {32'd0, b};
    assign abs_a = (div_signed && a[31]) ? -a : a;
    assign abs_b = (div_signed && b[31]) ? -b : b;

    // Restoring step: the sign of the 33-bit difference is the inverted quotient bit.
    assign rem_shift = {rem_reg, dvd_reg[iter_reg]};
    assign rem_diff  = rem_shift - {1'b0, dsr_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (operation == OP_MULT || operation == OP_MULTU)) begin
                    state_next = MUL;
                end else if (accept && (operation == OP_DIV || operation == OP_DIVU) && b != 32'd0) begin
                    state_next = DIV;
                end
            end
            MUL:     if (cnt_reg == 4'd0) state_next = IDLE;
            DIV:     if (iter_reg == 5'd0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        stall   = hilo_op && busy;
        rd_data = 32'd0;
        if (op_valid && operation == OP_MFHI) begin
            rd_data = hi_reg;
        end else if (op_valid && operation == OP_MFLO) begin
            rd_data = lo_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            done_reg  <= 1'b0;
            prod_reg  <= 64'd0;
            cnt_reg   <= 4'd0;
            dvd_reg   <= 32'd0;
            dsr_reg   <= 32'd0;
            rem_reg   <= 32'd0;
            quo_reg   <= 32'd0;
            iter_reg  <= 5'd0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!flush) begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            case (operation)
                                OP_MULT: begin
                                    prod_reg <= mul_s;
                                    cnt_reg  <= CNT_INIT;
                                end
                                OP_MULTU: begin
                                    prod_reg <= mul_u;
                                    cnt_reg  <= CNT_INIT;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (b == 32'd0) begin
                                        lo_reg   <= 32'hFFFF_FFFF;
                                        hi_reg   <= a;
                                        done_reg <= 1'b1;
                                    end else begin
                                        dvd_reg   <= abs_a;
                                        dsr_reg   <= abs_b;
                                        q_neg_reg <= div_signed && (a[31] ^ b[31]);
                                        r_neg_reg <= div_signed && a[31];
                                        rem_reg   <= 32'd0;
                                        quo_reg   <= 32'd0;
                                        iter_reg  <= 5'd31;
                                    end
                                end
                                OP_MTHI: hi_reg <= a;
                                OP_MTLO: lo_reg <= a;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt_reg == 4'd0) begin
                            hi_reg   <= prod_reg[63:32];
                            lo_reg   <= prod_reg[31:0];
                            done_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                    DIV: begin
                        rem_reg           <= rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
                        quo_reg[iter_reg] <= ~rem_diff[32];
                        iter_reg          <= iter_reg - 5'd1;
                    end
                    FIX: begin
                        lo_reg   <= q_neg_reg ? -quo_reg : quo_reg;
                        hi_reg   <= r_neg_reg ? -rem_reg : rem_reg;
                        done_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic HI/LO model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 4;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    logic        clk = 1'b0;
    logic        reset, op_valid, flush;
    logic [4:0]  operation;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] rd_data, hi_out, lo_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .operation(operation),
        .a(a), .b(b), .flush(flush), .stall(stall), .busy(busy), .done(done),
        .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted op, from plain arithmetic.
    task automatic model_apply(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                               output int lat, output logic exp_done);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        lat = 0;
        exp_done = 1'b0;
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                hi_m = p[63:32]; lo_m = p[31:0];
                lat = MUL_LAT; exp_done = 1'b1;
            end
            OP_MULTU: begin
                p = {32'd0, av} * {32'd0, bv};
                hi_m = p[63:32]; lo_m = p[31:0];
                lat = MUL_LAT; exp_done = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                exp_done = 1'b1;
                if (bv == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = av;
                end else begin
                    if (op == OP_DIVU) begin
                        sa = longint'({32'd0, av});
                        sb = longint'({32'd0, bv});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                    lat = 33;
                end
            end
            OP_MTHI: hi_m = av;
            OP_MTLO: lo_m = av;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
        int lat, n;
        logic exp_done;
        logic [31:0] old_lo;
        old_lo = lo_m;
        op_valid = 1'b1; operation = op; a = av; b = bv;
        #1;
        check("stall_idle", stall, 1'b0);
        if (op == OP_MFHI)      check("mfhi_data", rd_data, hi_m);
        else if (op == OP_MFLO) check("mflo_data", rd_data, lo_m);
        else                    check("rd_zero", rd_data, 32'd0);
        model_apply(op, av, bv, lat, exp_done);
        tick();
        op_valid = 1'b0; operation = 5'd0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            check("done_early", done, 1'b0);
            if (n == 3) begin
                op_valid = 1'b1; operation = OP_MFLO;
                #1;
                check("stall_busy", stall, 1'b1);
                check("rd_old", rd_data, old_lo);
                operation = 5'b00000;
                #1;
                check("stall_alu", stall, 1'b0);
                op_valid = 1'b0;
            end
            tick();
        end
        check("latency", n, lat);
        check("done", done, exp_done);
        check("hi", hi_out, hi_m);
        check("lo", lo_out, lo_m);
        $display("op=%b a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, av, bv, n, hi_out, lo_out);
    endtask

    logic [4:0] rand_ops [8] = '{OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; operation = 5'd0; a = 32'd0; b = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);

        run_op(OP_MTHI, 32'h1234_5678, 32'd0);
        run_op(OP_MFHI, 32'd0, 32'd0);
        run_op(OP_MFLO, 32'd0, 32'd0);
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_MFLO, 32'd0, 32'd0);
        run_op(OP_DIVU, 32'd100, 32'd7);
        run_op(OP_DIV, 32'd5, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(OP_MFHI, 32'd0, 32'd0);

        // Flush mid-multiply: no result, no done pulse, HI untouched.
        run_op(OP_MTHI, 32'hAAAA_0000, 32'd0);
        op_valid = 1'b1; operation = OP_MULT; a = 32'd7; b = 32'd9;
        tick();
        op_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("flush_done", done, 1'b0);
            tick();
        end
        check("flush_hi", hi_out, 32'hAAAA_0000);

        // Ops presented together with flush are discarded.
        op_valid = 1'b1; operation = OP_MTHI; a = 32'h5555_5555; flush = 1'b1;
        tick();
        check("flush_mthi", hi_out, 32'hAAAA_0000);
        operation = OP_DIV; a = 32'd9; b = 32'd0;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        check("flush_div0_done", done, 1'b0);
        check("flush_div0_lo", lo_out, lo_m);
        $display("flush sequence hi=%h lo=%h", hi_out, lo_out);

        for (int t = 0; t < 60; t++) begin
            run_op(rand_ops[$urandom_range(0, 7)], rand_operand(), rand_operand());
        end

        // Reset mid-divide clears HI/LO and returns to idle.
        op_valid = 1'b1; operation = OP_DIV; a = 32'd1000; b = 32'd3;
        tick();
        op_valid = 1'b0;
        repeat (10) tick();
        check("div_running", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        repeat (40) begin
            check("rst_mid_done", done, 1'b0);
            tick();
        end
        $display("reset mid-div hi=%h lo=%h", hi_out, lo_out);
        run_op(OP_DIVU, 32'd100, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
